activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
- Parametrised successor to the fixed ReLU stage: applies a run-time-selectable activation (ReLU, leaky ReLU, clipped ReLU, bypass) to a signed fixed-point feature map of NUM_CHANNELS x FRAMES_PER_CHANNEL elements.
- Sits between conv layers in the decoder datapath.
- Processes LANES elements per cycle under a start/done-tick handshake.
- Also counts negative inputs for sparsity statistics.

Parameters:
- NUM_CHANNELS, 2, channel count (>=1).
- FRAMES_PER_CHANNEL, 4, frames per channel (>=1).
- DATA_WIDTH, 16, signed element width (Q8.8 at default).
- LANES, 1, elements processed per cycle; must divide NUM_CHANNELS*FRAMES_PER_CHANNEL.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_mode  input  2  0=ReLU, 1=leaky ReLU, 2=clipped ReLU, 3=bypass; latched at start.
- i_leak_shift  input  4  leaky right-shift amount; latched at start.
- i_clip_max  input  DATA_WIDTH  signed clip ceiling; latched at start.
- i_data  input  [NUM_CHANNELS][FRAMES_PER_CHANNEL] x DATA_WIDTH signed  input map; snapshotted at start.
- o_busy  output  1  high while in RUN.
- o_done_tick  output  1  one-cycle completion pulse.
- o_result  output  [NUM_CHANNELS][FRAMES_PER_CHANNEL] x DATA_WIDTH signed  result map.
- o_neg_count  output  $clog2(N+1), where N=NUM_CHANNELS*FRAMES_PER_CHANNEL  number of inputs < 0 in the last run.

Behaviour:
- Reset (asynchronous assert, any state): state=IDLE; o_busy=0; o_done_tick=0; all o_result elements=0; o_neg_count=0; element index=0; latched config=0.
- FSM states are IDLE and RUN.
- IDLE -> RUN on a clock edge E with i_start=1. At edge E:
  - snapshot i_data into an internal buffer;
  - latch i_mode, i_leak_shift and i_clip_max;
  - clear index and o_neg_count;
  - set o_busy=1.
- Element order: flat index k = ch*FRAMES_PER_CHANNEL + fr, ascending.
- In RUN, each edge E+1 .. E+N/LANES:
  - computes elements k..k+LANES-1 from the snapshot;
  - writes them to o_result;
  - adds the count of negative elements in the group to o_neg_count;
  - advances k by LANES.
- On the edge that writes the final group, the FSM:
  - returns to IDLE;
  - sets o_busy=0;
  - sets o_done_tick=1 for exactly that following cycle.
- o_result and o_neg_count are final and valid when o_done_tick is high.
- o_done_tick deasserts at the next edge.
- Latency: start edge E -> o_done_tick high after edge E+N/LANES. At defaults (N=8, LANES=1) that is 8 cycles.
- During RUN, o_result is partially updated; unwritten elements keep their previous values. Consumers read only on o_done_tick.
- Results hold until the next start.
- i_start while in RUN is ignored; there is no queueing.
- i_start high on the same edge o_done_tick rises is ignored, because the FSM is still in RUN. A start is accepted on the following edge, giving back-to-back runs with a one-cycle gap.
- i_data and config changes after the start edge have no effect on the current run.
- Arithmetic (x = input element, y = output):
  - mode 0 (ReLU): y = x<0 ? 0 : x.
  - mode 1 (leaky ReLU): y = x<0 ? (x >>> i_leak_shift) : x. The shift is arithmetic and rounds toward minus infinity; shift 0 gives the identity.
  - mode 2 (clipped ReLU): y = min(max(x,0), clip). If i_clip_max<0, clip is treated as 0, so every output is 0.
  - mode 3 (bypass): y = x.
- No result exceeds DATA_WIDTH, so no saturation logic is needed.
- o_neg_count counts x<0 strictly (x=0 is not negative) and is independent of mode.
- Reset mid-RUN aborts the run immediately: all outputs clear and no done tick is produced.

Test Plan:
- Defaults, mode 0, input ch0={363,-542,0,338}, ch1={-1,609,-32768,380} -> o_done_tick exactly 8 cycles after the start edge, one cycle wide; o_result={363,0,0,338},{0,609,0,380}; o_neg_count=3.
- Mode 1, shift 3, same input -> {363,-68,0,338},{-1,609,-4096,380}; -542>>>3=-68 and -1>>>3=-1; o_neg_count=3.
- Mode 2, i_clip_max=512, same input -> {363,0,0,338},{0,512,0,380}. Rerun with i_clip_max=-5 -> all outputs 0.
- Mode 3 with LANES=2 -> o_result equals the input; o_done_tick exactly 4 cycles after start; o_busy high for those 4 cycles.
- Robustness: pulse i_start and change i_data mid-run -> results still match the original snapshot, with exactly one done tick. Assert rst_n low at cycle 3 of a run -> all outputs 0 immediately, no done tick. A subsequent start completes normally.
- Back-to-back: i_start held high continuously -> done ticks repeat every N/LANES+1 cycles; results track the i_data sampled at each accepted start.

Source files
------------

// File: rtl/activation_unit_if.sv
// Handshake and data bundle for activation_unit.
// master drives start/config/map; slave returns busy/done/result/count.
interface activation_unit_if #(
    parameter int NUM_CHANNELS       = 2,
    parameter int FRAMES_PER_CHANNEL = 4,
    parameter int DATA_WIDTH         = 16
);
    localparam int N  = NUM_CHANNELS * FRAMES_PER_CHANNEL;
    localparam int CW = $clog2(N + 1);

    logic                         i_start;
    logic [1:0]                   i_mode;
    logic [3:0]                   i_leak_shift;
    logic signed [DATA_WIDTH-1:0] i_clip_max;
    logic [NUM_CHANNELS-1:0]
          [FRAMES_PER_CHANNEL-1:0]
          [DATA_WIDTH-1:0]        i_data;
    logic                         o_busy;
    logic                         o_done_tick;
    logic [NUM_CHANNELS-1:0]
          [FRAMES_PER_CHANNEL-1:0]
          [DATA_WIDTH-1:0]        o_result;
    logic [CW-1:0]                o_neg_count;

    modport master (
        output i_start, i_mode, i_leak_shift,
        output i_clip_max, i_data,
        input  o_busy, o_done_tick,
        input  o_result, o_neg_count
    );

    modport slave (
        input  i_start, i_mode, i_leak_shift,
        input  i_clip_max, i_data,
        output o_busy, o_done_tick,
        output o_result, o_neg_count
    );
endinterface

// File: rtl/activation_unit.sv
// Run-time selectable activation over a snapshotted feature map.
// Ports: clk, rst_n (async low), bus (activation_unit_if.slave).
module activation_unit #(
    parameter int NUM_CHANNELS       = 2,
    parameter int FRAMES_PER_CHANNEL = 4,
    parameter int DATA_WIDTH         = 16,
    parameter int LANES              = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    activation_unit_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int N  = NUM_CHANNELS * FRAMES_PER_CHANNEL;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic                 busy;
    logic                 done_tick;
    logic [IW-1:0]        idx;
    logic [1:0]           mode_q;
    logic [3:0]           shift_q;
    logic signed [DW-1:0] clip_q;
    // Flat views: element k = ch*FRAMES_PER_CHANNEL + fr.
    logic [N-1:0][DW-1:0] snap;
    logic [N-1:0][DW-1:0] result;
    logic [CW-1:0]        neg_count;

    logic [LANES-1:0][DW-1:0] grp_y;
    logic [CW-1:0]            grp_neg;

    function automatic logic [DW-1:0] act(
        input logic signed [DW-1:0] x,
        input logic [1:0]           m,
        input logic [3:0]           sh,
        input logic signed [DW-1:0] clip
    );
        logic signed [DW-1:0] c;
        logic signed [DW-1:0] y;
        // A negative ceiling collapses clipped ReLU to all-zero.
        c = clip[DW-1] ? '0 : clip;
        unique case (1'b1)
            (m == 2'd0): y = x[DW-1] ? '0 : x;
            (m == 2'd1): y = x[DW-1] ? (x >>> sh) : x;
            (m == 2'd2): y = x[DW-1] ? '0 : ((x > c) ? c : x);
            default:     y = x;
        endcase
        return y;
    endfunction

    always_comb begin
        grp_y   = '0;
        grp_neg = '0;
        for (int l = 0; l < LANES; l++) begin
            grp_y[l] = act(snap[int'(idx) + l], mode_q,
                           shift_q, clip_q);
            grp_neg  = grp_neg
                     + CW'(snap[int'(idx) + l][DW-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done_tick <= 1'b0;
            idx       <= '0;
            mode_q    <= '0;
            shift_q   <= '0;
            clip_q    <= '0;
            snap      <= '0;
            result    <= '0;
            neg_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_tick <= 1'b0;
                    if (bus.i_start) begin
                        snap      <= bus.i_data;
                        mode_q    <= bus.i_mode;
                        shift_q   <= bus.i_leak_shift;
                        clip_q    <= bus.i_clip_max;
                        idx       <= '0;
                        neg_count <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++)
                        result[int'(idx) + l] <= grp_y[l];
                    neg_count <= neg_count + grp_neg;
                    if (idx == IW'(N - LANES)) begin
                        idx       <= '0;
                        busy      <= 1'b0;
                        done_tick <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + IW'(LANES);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_done_tick = done_tick;
    assign bus.o_result    = result;
    assign bus.o_neg_count = neg_count;
endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit (LANES=1 and LANES=2).
// Driver pushes expectations; monitors pop on o_done_tick.
module tb_activation_unit;
    localparam int NC = 2;
    localparam int FPC = 4;
    localparam int DW = 16;
    localparam int N = NC * FPC;

    typedef logic [N*DW-1:0] vec_t;
    typedef struct {
        vec_t res;
        int   neg;
        int   done_c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    exp_t q1[$];
    exp_t q2[$];

    activation_unit_if #(NC, FPC, DW) b1();
    activation_unit_if #(NC, FPC, DW) b2();

    activation_unit #(
        .NUM_CHANNELS(NC), .FRAMES_PER_CHANNEL(FPC),
        .DATA_WIDTH(DW), .LANES(1)
    ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    activation_unit #(
        .NUM_CHANNELS(NC), .FRAMES_PER_CHANNEL(FPC),
        .DATA_WIDTH(DW), .LANES(2)
    ) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(string nm, vec_t a, vec_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic chk_i(string nm, int a, int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    function automatic vec_t mk(int a0, int a1, int a2, int a3,
                                int a4, int a5, int a6, int a7);
        int   v[8];
        vec_t r;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[k*DW +: DW] = v[k][DW-1:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (b1.o_done_tick === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_unexpected_done: cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("u1_result", vec_t'(b1.o_result), e.res);
                chk_i("u1_neg", int'(b1.o_neg_count), e.neg);
                chk_i("u1_done_cycle", cyc, e.done_c);
            end
        end
    end

    always @(negedge clk) begin
        if (b2.o_done_tick === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u2_unexpected_done: cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("u2_result", vec_t'(b2.o_result), e.res);
                chk_i("u2_neg", int'(b2.o_neg_count), e.neg);
                chk_i("u2_done_cycle", cyc, e.done_c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0 ||
                b1.o_busy || b2.o_busy) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL wait_idle: timeout got %0d want <40", n);
            q1.delete();
            q2.delete();
        end
        tick();
    endtask

    task automatic run1(logic [1:0] m, logic [3:0] sh, int clip,
                        vec_t d, vec_t er, int en);
        exp_t e;
        b1.i_mode       = m;
        b1.i_leak_shift = sh;
        b1.i_clip_max   = clip[DW-1:0];
        b1.i_data       = d;
        b1.i_start      = 1'b1;
        tick();
        b1.i_start = 1'b0;
        e.res    = er;
        e.neg    = en;
        e.done_c = cyc + 8;
        q1.push_back(e);
        wait_idle();
    endtask

    vec_t v, vb, vc, zero;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   s;
        v    = mk(363, -542, 0, 338, -1, 609, -32768, 380);
        vb   = mk(1, 2, 3, 4, -5, 6, -7, 8);
        vc   = mk(-100, -200, 300, 0, 0, 0, 0, -1);
        zero = '0;
        rst_n = 1'b0;
        b1.i_start = 0; b1.i_mode = 0; b1.i_leak_shift = 0;
        b1.i_clip_max = 0; b1.i_data = '0;
        b2.i_start = 0; b2.i_mode = 0; b2.i_leak_shift = 0;
        b2.i_clip_max = 0; b2.i_data = '0;
        #1;
        chk("rst_result", vec_t'(b1.o_result), zero);
        chk_i("rst_neg", int'(b1.o_neg_count), 0);
        chk_i("rst_busy", int'(b1.o_busy), 0);
        chk_i("rst_done", int'(b1.o_done_tick), 0);
        #20;
        rst_n = 1'b1;
        tick();

        run1(2'd0, 4'd0, 0, v,
             mk(363, 0, 0, 338, 0, 609, 0, 380), 3);
        run1(2'd1, 4'd3, 0, v,
             mk(363, -68, 0, 338, -1, 609, -4096, 380), 3);
        run1(2'd1, 4'd15, 0, v,
             mk(363, -1, 0, 338, -1, 609, -1, 380), 3);
        run1(2'd1, 4'd0, 0, v, v, 3);
        run1(2'd2, 4'd0, 512, v,
             mk(363, 0, 0, 338, 0, 512, 0, 380), 3);
        run1(2'd2, 4'd0, -5, v, zero, 3);
        run1(2'd3, 4'd0, 0, vb, vb, 2);

        // LANES=2 bypass with busy window
        b2.i_mode  = 2'd3;
        b2.i_data  = v;
        b2.i_start = 1'b1;
        tick();
        b2.i_start = 1'b0;
        e.res = v; e.neg = 3; e.done_c = cyc + 4;
        q2.push_back(e);
        for (int i = 0; i < 4; i++) begin
            chk_i("u2_busy_run", int'(b2.o_busy), 1);
            tick();
        end
        chk_i("u2_busy_end", int'(b2.o_busy), 0);
        wait_idle();

        // mid-run start pulse and data change are ignored
        b1.i_mode  = 2'd0;
        b1.i_data  = v;
        b1.i_start = 1'b1;
        tick();
        b1.i_start = 1'b0;
        e.res = mk(363, 0, 0, 338, 0, 609, 0, 380);
        e.neg = 3; e.done_c = cyc + 8;
        q1.push_back(e);
        tick();
        tick();
        b1.i_start = 1'b1;
        b1.i_data  = vc;
        tick();
        b1.i_start = 1'b0;
        wait_idle();
        repeat (10) tick();

        // reset at cycle 3 of a run aborts it
        b1.i_mode  = 2'd3;
        b1.i_data  = vb;
        b1.i_start = 1'b1;
        tick();
        b1.i_start = 1'b0;
        e.res = vb; e.neg = 2; e.done_c = cyc + 8;
        q1.push_back(e);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_result", vec_t'(b1.o_result), zero);
        chk_i("abort_neg", int'(b1.o_neg_count), 0);
        chk_i("abort_busy", int'(b1.o_busy), 0);
        chk_i("abort_done", int'(b1.o_done_tick), 0);
        q1.delete();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        run1(2'd0, 4'd0, 0, v,
             mk(363, 0, 0, 338, 0, 609, 0, 380), 3);

        // back-to-back with start held high
        b1.i_mode  = 2'd3;
        b1.i_data  = v;
        b1.i_start = 1'b1;
        tick();
        s = cyc;
        e.res = v;  e.neg = 3; e.done_c = s + 8;
        q1.push_back(e);
        b1.i_data = vb;
        e.res = vb; e.neg = 2; e.done_c = s + 17;
        q1.push_back(e);
        repeat (9) tick();
        b1.i_data = vc;
        e.res = vc; e.neg = 3; e.done_c = s + 26;
        q1.push_back(e);
        repeat (9) tick();
        b1.i_start = 1'b0;
        b1.i_data  = v;
        wait_idle();
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
